// File: rtl/demux_serializer_if.sv
// Handshake/bus bundle for demux_serializer: word input with select, per-channel beat outputs.
interface demux_serializer_if #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int SEL_WIDTH  = 2
);
    logic [SEL_WIDTH-1:0]         select;
    logic [MST_DWIDTH-1:0]        data_i;
    logic                         valid_i;
    logic                         ready_o;
    logic [NUM_CH*SYS_DWIDTH-1:0] data_o;
    logic [NUM_CH-1:0]            valid_o;
    logic                         busy_o;
    logic                         drop_o;

    modport master (
        output select, data_i, valid_i,
        input  ready_o, data_o, valid_o, busy_o, drop_o
    );

    modport slave (
        input  select, data_i, valid_i,
        output ready_o, data_o, valid_o, busy_o, drop_o
    );
endinterface

// File: rtl/demux_serializer.sv
// Word FIFO + serialiser that steers MST_DWIDTH words as SYS_DWIDTH beats to one of NUM_CH channels.
// Define DEMUX_LSB_FIRST_EN to emit beats least-significant first (default is MSB first).
module demux_serializer_lane #(
    parameter int SYS_DWIDTH = 8,
    parameter int SEL_WIDTH  = 2,
    parameter int LANE_ID    = 0
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic                  beat_vld,
    input  logic [SEL_WIDTH-1:0]  beat_sel,
    input  logic [SYS_DWIDTH-1:0] beat,
    output logic                  vld,
    output logic [SYS_DWIDTH-1:0] data
);
    localparam logic [SEL_WIDTH-1:0] ID = SEL_WIDTH'(LANE_ID);

    logic hit;
    assign hit = beat_vld && (beat_sel == ID);

    // Data is forced to zero whenever this lane is not the target.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            vld  <= hit;
            data <= hit ? beat : '0;
        end
    end
endmodule

module demux_serializer #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8,
    parameter int NUM_CH     = 3,
    parameter int SEL_WIDTH  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk_sys,
    input logic              rst,
    demux_serializer_if.slave bus
);
    localparam int RATIO = MST_DWIDTH / SYS_DWIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(RATIO);

    localparam logic [AW:0]        DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]      LAST     = CW'(RATIO - 1);
    localparam logic [SEL_WIDTH:0] NUM_CH_W = (SEL_WIDTH+1)'(NUM_CH);

    typedef struct packed {
        logic [SEL_WIDTH-1:0]  sel;
        logic [MST_DWIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DROP} state_t;

    function automatic logic [SYS_DWIDTH-1:0] first_beat(input logic [MST_DWIDTH-1:0] w);
`ifdef DEMUX_LSB_FIRST_EN
        return w[SYS_DWIDTH-1:0];
`else
        return w[MST_DWIDTH-1 -: SYS_DWIDTH];
`endif
    endfunction

    function automatic logic [MST_DWIDTH-1:0] shift_word(input logic [MST_DWIDTH-1:0] w);
`ifdef DEMUX_LSB_FIRST_EN
        return w >> SYS_DWIDTH;
`else
        return w << SYS_DWIDTH;
`endif
    endfunction

    // Word FIFO
    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop, fifo_ne;
    entry_t          head;

    state_t                state;
    logic [CW-1:0]         beat_cnt;
    logic [MST_DWIDTH-1:0] shreg;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic                  drop_q;
    logic                  sel_ok;
    state_t                next_word;

    assign head        = mem[rd_ptr];
    assign fifo_ne     = (count != '0);
    assign bus.ready_o = (count != DEPTH_C);
    assign push        = bus.valid_i && bus.ready_o;
    assign pop         = (state == LOAD);
    assign sel_ok      = ({1'b0, head.sel} < NUM_CH_W);
    assign next_word   = fifo_ne ? LOAD : IDLE;

    always_ff @(posedge clk_sys) begin
        if (push) mem[wr_ptr] <= {bus.select, bus.data_i};
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // LOAD emits beat 0 straight from the FIFO head, so shreg holds the remaining beats.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            shreg    <= '0;
            sel_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            case (state)
                IDLE: if (fifo_ne) state <= LOAD;
                LOAD: begin
                    shreg    <= shift_word(head.data);
                    sel_q    <= head.sel;
                    beat_cnt <= '0;
                    if (sel_ok) begin
                        state <= SHIFT;
                    end else begin
                        state  <= DROP;
                        drop_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (beat_cnt == LAST) begin
                        state <= next_word;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                        shreg    <= shift_word(shreg);
                    end
                end
                DROP:    state <= next_word;
                default: state <= IDLE;
            endcase
        end
    end

    // Next beat presented to the lane registers.
    logic                  beat_vld_nxt;
    logic [SEL_WIDTH-1:0]  sel_nxt;
    logic [SYS_DWIDTH-1:0] beat_nxt;

    always_comb begin
        beat_vld_nxt = 1'b0;
        sel_nxt      = sel_q;
        beat_nxt     = '0;
        if (state == LOAD) begin
            beat_vld_nxt = sel_ok;
            sel_nxt      = head.sel;
            beat_nxt     = first_beat(head.data);
        end else if (state == SHIFT && beat_cnt != LAST) begin
            beat_vld_nxt = 1'b1;
            beat_nxt     = first_beat(shreg);
        end
    end

    logic [NUM_CH-1:0]                 lane_vld;
    logic [NUM_CH-1:0][SYS_DWIDTH-1:0] lane_data;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        demux_serializer_lane #(
            .SYS_DWIDTH (SYS_DWIDTH),
            .SEL_WIDTH  (SEL_WIDTH),
            .LANE_ID    (k)
        ) u_lane (
            .clk_sys  (clk_sys),
            .rst      (rst),
            .beat_vld (beat_vld_nxt),
            .beat_sel (sel_nxt),
            .beat     (beat_nxt),
            .vld      (lane_vld[k]),
            .data     (lane_data[k])
        );
    end

    assign bus.valid_o = lane_vld;
    assign bus.data_o  = lane_data;
    assign bus.drop_o  = drop_q;
    assign bus.busy_o  = fifo_ne || (state != IDLE);
endmodule

// File: tb/tb_demux_serializer.sv
// Bench for demux_serializer: timeline model of accepted words checked every cycle, plus literal beat checks.
module tb_demux_serializer;
    localparam int NCH = 3, DEP = 4, RATIO = 4, MAXC = 1024;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    demux_serializer_if #(.MST_DWIDTH(32), .SYS_DWIDTH(8),  .NUM_CH(3), .SEL_WIDTH(2)) bus_a();
    demux_serializer_if #(.MST_DWIDTH(64), .SYS_DWIDTH(16), .NUM_CH(4), .SEL_WIDTH(2)) bus_b();

    demux_serializer #(.MST_DWIDTH(32), .SYS_DWIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .FIFO_DEPTH(4))
        u_dut_a (.clk_sys(clk_sys), .rst(rst), .bus(bus_a));
    demux_serializer #(.MST_DWIDTH(64), .SYS_DWIDTH(16), .NUM_CH(4), .SEL_WIDTH(2), .FIFO_DEPTH(4))
        u_dut_b (.clk_sys(clk_sys), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] beat_of(input logic [31:0] w, input int b);
`ifdef DEMUX_LSB_FIRST_EN
        return 8'(w >> (b * 8));
`else
        return 8'(w >> ((RATIO - 1 - b) * 8));
`endif
    endfunction

    // Model: each accepted word gets a first-beat cycle L; outputs are a per-cycle schedule.
    int          cyc = 0;
    logic [2:0]  exp_v    [MAXC];
    logic [23:0] exp_d    [MAXC];
    logic        exp_drop [MAXC];
    int          pend_l[$];
    int          next_min = 0;
    int          last_end = -1;
    bit          m_acc = 1'b0;
    bit          chk_en = 1'b0;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_v[i] = '0; exp_d[i] = '0; exp_drop[i] = 1'b0;
        end
    end

    always @(posedge clk_sys) begin
        int l, s;
        logic [31:0] w;
        cyc++;
        m_acc = 1'b0;
        if (rst) begin
            pend_l.delete();
            next_min = 0;
            last_end = -1;
            for (int i = cyc; i < MAXC; i++) begin
                exp_v[i] = '0; exp_d[i] = '0; exp_drop[i] = 1'b0;
            end
        end else begin
            if (bus_a.valid_i && pend_l.size() != DEP) begin
                m_acc = 1'b1;
                l = (cyc + 2 > next_min) ? cyc + 2 : next_min;
                s = int'(bus_a.select);
                w = bus_a.data_i;
                if (l + RATIO < MAXC) begin
                    if (s >= NCH) begin
                        exp_drop[l] = 1'b1;
                        last_end = l;
                        next_min = l + 2;
                    end else begin
                        for (int b = 0; b < RATIO; b++) begin
                            exp_v[l+b] = 3'(1 << s);
                            exp_d[l+b] = 24'(beat_of(w, b)) << (8 * s);
                        end
                        last_end = l + RATIO - 1;
                        next_min = l + RATIO + 1;
                    end
                end
            end
            while (pend_l.size() > 0 && pend_l[0] <= cyc) void'(pend_l.pop_front());
            if (m_acc) pend_l.push_back(l);
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en && cyc < MAXC) begin
            if (rst) begin
                check("rst_ready", bus_a.ready_o, 1);
                check("rst_valid", bus_a.valid_o, 0);
                check("rst_data",  bus_a.data_o,  0);
                check("rst_busy",  bus_a.busy_o,  0);
                check("rst_drop",  bus_a.drop_o,  0);
            end else begin
                check("valid_o", bus_a.valid_o, exp_v[cyc]);
                check("data_o",  bus_a.data_o,  exp_d[cyc]);
                check("drop_o",  bus_a.drop_o,  exp_drop[cyc]);
                check("ready_o", bus_a.ready_o, pend_l.size() != DEP);
                check("busy_o",  bus_a.busy_o,  (pend_l.size() != 0) || (cyc <= last_end));
            end
        end
    end

    bit saw_stall = 1'b0;
    bit saw_ready_low = 1'b0;

    task automatic send(input logic [1:0] s, input logic [31:0] w);
        bit done;
        done = 1'b0;
        @(negedge clk_sys);
        bus_a.select  = s;
        bus_a.data_i  = w;
        bus_a.valid_i = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk_sys);
            #1;
            if (m_acc) done = 1'b1;
            else begin
                saw_stall = 1'b1;
                if (!bus_a.ready_o) saw_ready_low = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: word %0h not accepted within 100 cycles", w);
        end
    endtask

    task automatic idle_a();
        @(negedge clk_sys);
        bus_a.valid_i = 1'b0;
    endtask

    logic [7:0]  lit_a [4];
    logic [15:0] lit_b [4];
    logic [1:0]  burst_sel [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef DEMUX_LSB_FIRST_EN
        lit_a = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        lit_b = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
`else
        lit_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        lit_b = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
`endif
        burst_sel = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        bus_a.valid_i = 1'b0; bus_a.select = '0; bus_a.data_i = '0;
        bus_b.valid_i = 1'b0; bus_b.select = '0; bus_b.data_i = '0;

        repeat (2) @(posedge clk_sys);
        chk_en = 1'b1;
        @(negedge clk_sys);
        #2 rst = 1'b0;
        @(negedge clk_sys);
        check("idle_ready", bus_a.ready_o, 1);
        check("idle_valid", bus_a.valid_o, 0);
        check("idle_data",  bus_a.data_o,  0);
        check("idle_busy",  bus_a.busy_o,  0);
        check("idle_b_ready", bus_b.ready_o, 1);

        // Single word to channel 1: two silent cycles, then four beats.
        send(2'd1, 32'hA1B2C3D4);
        idle_a();
        check("single_lat0", bus_a.valid_o, 0);
        @(negedge clk_sys);
        check("single_lat1", bus_a.valid_o, 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_sys);
            check("single_v", bus_a.valid_o, 3'b010);
            check("single_d", bus_a.data_o, {8'h00, lit_a[b], 8'h00});
        end
        @(negedge clk_sys);
        check("single_end", bus_a.valid_o, 0);
        repeat (10) @(negedge clk_sys);

        // Burst of six with valid held high.
        for (int i = 0; i < 6; i++) send(burst_sel[i], 32'h10203040 + 32'(i) * 32'h01010101);
        idle_a();
        check("burst_stall", saw_stall, 1);
        check("burst_ready_low", saw_ready_low, 1);
        repeat (40) @(negedge clk_sys);
        check("burst_drained", bus_a.busy_o, 0);

        // Out-of-range select is dropped; following word still goes out.
        send(2'd3, 32'h11223344);
        idle_a();
        @(negedge clk_sys);
        check("drop_early", bus_a.drop_o, 0);
        @(negedge clk_sys);
        check("drop_pulse", bus_a.drop_o, 1);
        check("drop_novalid", bus_a.valid_o, 0);
        send(2'd0, 32'h55667788);
        idle_a();
        repeat (10) @(negedge clk_sys);

        // Reset two beats into a word with two words still queued.
        send(2'd2, 32'hCAFE0001);
        send(2'd2, 32'hCAFE0002);
        send(2'd2, 32'hCAFE0003);
        idle_a();
        @(negedge clk_sys);
        check("pre_rst_beat2", bus_a.valid_o, 3'b100);
        #2 rst = 1'b1;
        #1;
        check("async_valid", bus_a.valid_o, 0);
        check("async_data",  bus_a.data_o,  0);
        check("async_ready", bus_a.ready_o, 1);
        check("async_busy",  bus_a.busy_o,  0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("post_rst_busy", bus_a.busy_o, 0);

        // Wide configuration: 64-bit word, 16-bit beats, channel 3.
        @(negedge clk_sys);
        bus_b.select  = 2'd3;
        bus_b.data_i  = 64'h0123456789ABCDEF;
        bus_b.valid_i = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        bus_b.valid_i = 1'b0;
        check("wide_lat0", bus_b.valid_o, 0);
        @(negedge clk_sys);
        check("wide_lat1", bus_b.valid_o, 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk_sys);
            check("wide_v", bus_b.valid_o, 4'b1000);
            check("wide_d", bus_b.data_o, {lit_b[b], 48'h0});
        end
        @(negedge clk_sys);
        check("wide_end", bus_b.valid_o, 0);

        repeat (5) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
